uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler feeding a byte-wide UART transmitter.
// Each packet is framed as header, payload bytes, then an XOR checksum (inverted on stall abort).
module uart_tx_scheduler #(
   parameter logic [3:0]  HEADER_MAGIC = 4'hA,
   parameter logic [15:0] STALL_LIMIT  = 16'd50000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ_VALID,
   input  logic [3:0]  REQ_LAST,
   input  logic [31:0] REQ_DATA,
   output logic [3:0]  REQ_ACK,
   output logic [7:0]  TX_DATA,
   output logic        TX_DATA_READY,
   input  logic        TX_IDLE,
   output logic        BUSY,
   output logic [1:0]  GRANT
);

   typedef enum logic [1:0] {ARB, HDR, PAY, CSUM} state_t;

   state_t      r_state, w_state_nx;
   logic [1:0]  r_grant, w_grant_nx;
   logic        r_busy, w_busy_nx;
   logic [7:0]  r_tx_data, w_tx_data_nx;
   logic        r_tx_ready, w_tx_ready_nx;
   logic [3:0]  r_ack, w_ack_nx;
   logic [7:0]  r_csum, w_csum_nx;
   logic [15:0] r_stall, w_stall_nx;
   logic        r_last_pend, w_last_pend_nx;
   logic        r_abort, w_abort_nx;

   logic        w_can_issue;
   logic        w_req_vld;
   logic        w_req_last;
   logic [7:0]  w_req_byte;
   logic [7:0]  w_hdr;

   function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
      logic [1:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k < 5; k++) begin
         idx = last + 2'(k);
         if (v[idx] && !found) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // The strobe cycle doubles as holdoff, which also keeps a just-acked byte from being resent.
   assign w_can_issue = TX_IDLE && !r_tx_ready;
   assign w_req_vld   = REQ_VALID[r_grant];
   assign w_req_last  = REQ_LAST[r_grant];
   assign w_req_byte  = REQ_DATA[{r_grant, 3'b000} +: 8];
   assign w_hdr       = {HEADER_MAGIC, 2'b00, r_grant};

   always_comb begin
      w_state_nx     = r_state;
      w_grant_nx     = r_grant;
      w_busy_nx      = r_busy;
      w_tx_data_nx   = r_tx_data;
      w_tx_ready_nx  = 1'b0;
      w_ack_nx       = 4'b0000;
      w_csum_nx      = r_csum;
      w_stall_nx     = r_stall;
      w_last_pend_nx = r_last_pend;
      w_abort_nx     = r_abort;
      case (r_state)
         ARB: begin
            if (|REQ_VALID) begin
               w_grant_nx     = rr_pick(REQ_VALID, r_grant);
               w_busy_nx      = 1'b1;
               w_stall_nx     = 16'd0;
               w_last_pend_nx = 1'b0;
               w_abort_nx     = 1'b0;
               w_state_nx     = HDR;
            end
         end
         HDR: begin
            if (w_can_issue) begin
               w_tx_data_nx  = w_hdr;
               w_tx_ready_nx = 1'b1;
               w_csum_nx     = w_hdr;
               w_state_nx    = PAY;
            end
         end
         PAY: begin
            // Stay in PAY through the ack cycle so REQ_ACK never shows outside PAY.
            if (r_last_pend) begin
               w_state_nx = CSUM;
            end else if (w_req_vld && w_can_issue) begin
               w_tx_data_nx   = w_req_byte;
               w_tx_ready_nx  = 1'b1;
               w_ack_nx       = 4'b0001 << r_grant;
               w_csum_nx      = r_csum ^ w_req_byte;
               w_stall_nx     = 16'd0;
               w_last_pend_nx = w_req_last;
            end else if (r_stall >= STALL_LIMIT) begin
               w_abort_nx = 1'b1;
               w_state_nx = CSUM;
            end else if (!w_req_vld && (r_stall != 16'hFFFF)) begin
               w_stall_nx = r_stall + 16'd1;
            end
         end
         CSUM: begin
            if (w_can_issue) begin
               w_tx_data_nx   = r_abort ? ~r_csum : r_csum;
               w_tx_ready_nx  = 1'b1;
               w_busy_nx      = 1'b0;
               w_last_pend_nx = 1'b0;
               w_state_nx     = ARB;
            end
         end
         default: w_state_nx = ARB;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ARB;
         r_grant     <= 2'd3;
         r_busy      <= 1'b0;
         r_tx_data   <= 8'h00;
         r_tx_ready  <= 1'b0;
         r_ack       <= 4'b0000;
         r_csum      <= 8'h00;
         r_stall     <= 16'd0;
         r_last_pend <= 1'b0;
         r_abort     <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_grant     <= w_grant_nx;
         r_busy      <= w_busy_nx;
         r_tx_data   <= w_tx_data_nx;
         r_tx_ready  <= w_tx_ready_nx;
         r_ack       <= w_ack_nx;
         r_csum      <= w_csum_nx;
         r_stall     <= w_stall_nx;
         r_last_pend <= w_last_pend_nx;
         r_abort     <= w_abort_nx;
      end
   end

   assign REQ_ACK       = r_ack;
   assign TX_DATA       = r_tx_data;
   assign TX_DATA_READY = r_tx_ready;
   assign BUSY          = r_busy;
   assign GRANT         = r_grant;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester and transmitter models drive the DUT,
// a packet-level reference model predicts the framed byte stream, a monitor compares it.
module tb_uart_tx_scheduler;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  REQ_VALID = 4'b0000;
   logic [3:0]  REQ_LAST = 4'b0000;
   logic [31:0] REQ_DATA = 32'h0;
   logic [3:0]  REQ_ACK;
   logic [7:0]  TX_DATA;
   logic        TX_DATA_READY;
   logic        TX_IDLE = 1'b1;
   logic        BUSY;
   logic [1:0]  GRANT;

   uart_tx_scheduler #(.HEADER_MAGIC(4'hA), .STALL_LIMIT(16'd8)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST),
      .REQ_DATA(REQ_DATA), .REQ_ACK(REQ_ACK), .TX_DATA(TX_DATA),
      .TX_DATA_READY(TX_DATA_READY), .TX_IDLE(TX_IDLE), .BUSY(BUSY), .GRANT(GRANT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic [3:0] ack;
      logic [1:0] grant;
      logic       busy;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rq_dat[4][$];
   logic       rq_last[4][$];
   logic [7:0] mdat[4][$];
   int         mlen[4][$];
   bit         mtrunc[4][$];
   int         m_last = 3;

   int         checks = 0;
   int         errors = 0;
   int         idle_mode = 0;
   int         idle_cnt = 0;
   int         payload_seen = 0;
   logic [3:0] pend = 4'b0000;
   logic       prev_rdy = 1'b0;
   logic       prev_idle = 1'b1;

   // Requesters advance one byte on the edge ending their ack cycle; transmitter model sets TX_IDLE.
   initial begin
      logic [3:0]  v, l;
      logic [31:0] d;
      forever begin
         @(posedge CLK);
         #1;
         for (int r = 0; r < 4; r++)
            if (pend[r] && rq_dat[r].size() > 0) begin
               void'(rq_dat[r].pop_front());
               void'(rq_last[r].pop_front());
            end
         pend = REQ_ACK;
         case (idle_mode)
            1: begin
               if (TX_DATA_READY) idle_cnt = 10;
               if (idle_cnt > 0) begin TX_IDLE = 1'b0; idle_cnt--; end
               else TX_IDLE = 1'b1;
            end
            2: TX_IDLE = ($urandom_range(0, 2) != 0);
            default: TX_IDLE = 1'b1;
         endcase
         v = 4'b0; l = 4'b0; d = $urandom;
         for (int r = 0; r < 4; r++)
            if (rq_dat[r].size() > 0) begin
               v[r] = 1'b1;
               l[r] = rq_last[r][0];
               d[8*r +: 8] = rq_dat[r][0];
            end
         REQ_VALID = v;
         REQ_LAST  = l;
         REQ_DATA  = d;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (!RST) begin
            if (TX_DATA_READY) begin
               checks++;
               if (prev_rdy) begin errors++; $display("FAIL back_to_back_strobe: strobe=1 after strobe=1, required gap"); end
               checks++;
               if (!prev_idle) begin errors++; $display("FAIL strobe_while_busy_tx: TX_IDLE prev=0, required 1"); end
               if (exp_q.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL unexpected_byte: got %02h, required no strobe", TX_DATA);
               end else begin
                  e = exp_q.pop_front();
                  checks++;
                  if (TX_DATA !== e.data) begin errors++; $display("FAIL tx_data: got %02h, required %02h", TX_DATA, e.data); end
                  checks++;
                  if (REQ_ACK !== e.ack) begin errors++; $display("FAIL req_ack: got %b, required %b (byte %02h)", REQ_ACK, e.ack, e.data); end
                  checks++;
                  if (GRANT !== e.grant) begin errors++; $display("FAIL grant: got %0d, required %0d (byte %02h)", GRANT, e.grant, e.data); end
                  checks++;
                  if (BUSY !== e.busy) begin errors++; $display("FAIL busy: got %b, required %b (byte %02h)", BUSY, e.busy, e.data); end
                  if (e.ack != 4'b0) payload_seen++;
               end
            end else begin
               checks++;
               if (REQ_ACK !== 4'b0000) begin errors++; $display("FAIL ack_without_strobe: got %b, required 0000", REQ_ACK); end
            end
         end
         prev_rdy  = TX_DATA_READY;
         prev_idle = TX_IDLE;
      end
   end

   task automatic add_pkt(input int r, input logic [31:0] bytes, input int n, input bit trunc);
      logic [7:0] b;
      mlen[r].push_back(n);
      mtrunc[r].push_back(trunc);
      for (int j = 0; j < n; j++) begin
         b = bytes[8*j +: 8];
         mdat[r].push_back(b);
         rq_dat[r].push_back(b);
         rq_last[r].push_back(!trunc && (j == n - 1));
      end
   endtask

   // Packet-level model: round-robin over requesters holding packets, framed with XOR checksum.
   task automatic model_run();
      int         r, n;
      bit         any, tr;
      logic [7:0] hdr, cs, b;
      forever begin
         any = 0;
         r = 0;
         for (int k = 1; k <= 4; k++)
            if (!any && mlen[(m_last + k) % 4].size() > 0) begin
               r = (m_last + k) % 4;
               any = 1;
            end
         if (!any) break;
         hdr = 8'hA0 | 8'(r);
         exp_q.push_back('{hdr, 4'b0000, 2'(r), 1'b1});
         cs = hdr;
         n = mlen[r].pop_front();
         for (int j = 0; j < n; j++) begin
            b = mdat[r].pop_front();
            cs ^= b;
            exp_q.push_back('{b, 4'b0001 << r, 2'(r), 1'b1});
         end
         tr = mtrunc[r].pop_front();
         exp_q.push_back('{tr ? ~cs : cs, 4'b0000, 2'(r), 1'b0});
         m_last = r;
      end
   endtask

   task automatic wait_done(input string name);
      int  n = 0;
      bit  pending = 1;
      while (pending && n < 6000) begin
         @(negedge CLK);
         n++;
         pending = (exp_q.size() != 0) || BUSY;
         for (int r = 0; r < 4; r++) if (rq_dat[r].size() != 0) pending = 1;
      end
      checks++;
      if (pending) begin
         errors++;
         $display("FAIL %s_timeout: %0d bytes still expected, busy=%b, required 0 and 0", name, exp_q.size(), BUSY);
         exp_q.delete();
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin errors++; $display("FAIL %s: got %02h, required %02h", name, got, req); end
   endtask

   initial begin
      int base, n;
      repeat (3) @(negedge CLK);
      check_val("rst_tx_data", TX_DATA, 8'h00);
      check_val("rst_tx_ready", {7'b0, TX_DATA_READY}, 8'h00);
      check_val("rst_ack", {4'b0, REQ_ACK}, 8'h00);
      check_val("rst_busy", {7'b0, BUSY}, 8'h00);
      check_val("rst_grant", {6'b0, GRANT}, 8'h03);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // two requesters alternate one-byte packets
      add_pkt(0, 32'h11, 1, 0); add_pkt(0, 32'h22, 1, 0);
      add_pkt(2, 32'h33, 1, 0); add_pkt(2, 32'h44, 1, 0);
      model_run(); wait_done("alternate");

      add_pkt(0, 32'h55, 1, 0);
      model_run(); wait_done("single");

      add_pkt(3, 32'h030201, 3, 0);
      model_run(); wait_done("three_byte");

      // payload without LAST: requester stalls and the packet is aborted
      add_pkt(1, 32'h10, 1, 1);
      model_run(); wait_done("stall_abort");
      check_val("abort_busy", {7'b0, BUSY}, 8'h00);

      idle_mode = 1;
      add_pkt(2, 32'hDEADBEEF, 4, 0); add_pkt(1, 32'h5A, 1, 0);
      model_run(); wait_done("slow_tx");

      for (int rnd = 0; rnd < 8; rnd++) begin
         idle_mode = (rnd % 3 == 1) ? 1 : ((rnd % 3 == 2) ? 2 : 0);
         for (int r = 0; r < 4; r++) begin
            n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++) add_pkt(r, $urandom, $urandom_range(1, 4), 0);
         end
         model_run(); wait_done("random");
      end

      // reset in the middle of a payload
      idle_mode = 0;
      base = payload_seen;
      add_pkt(2, 32'h04030201, 4, 0);
      model_run();
      n = 0;
      while (payload_seen < base + 2 && n < 500) begin @(negedge CLK); n++; end
      checks++;
      if (payload_seen < base + 2) begin errors++; $display("FAIL mid_reset_wait: payload bytes %0d, required 2", payload_seen - base); end
      RST = 1'b1;
      for (int r = 0; r < 4; r++) begin rq_dat[r].delete(); rq_last[r].delete(); end
      pend = 4'b0000;
      exp_q.delete();
      @(negedge CLK);
      check_val("midrst_busy", {7'b0, BUSY}, 8'h00);
      check_val("midrst_grant", {6'b0, GRANT}, 8'h03);
      check_val("midrst_tx_ready", {7'b0, TX_DATA_READY}, 8'h00);
      RST = 1'b0;
      m_last = 3;
      repeat (4) @(negedge CLK);
      add_pkt(2, 32'h77, 1, 0);
      model_run(); wait_done("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
